// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps the S select of a 4:1 mux, holds each value
// SETTLE+1 cycles, captures mux_o into a 4-bit word and hands it off via valid/ready.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] S,
    input  logic       mux_o,
    output logic [3:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for start, S parked at 0
    // SCAN  | stepping S 0..3, capturing mux_o at the end of each hold
    // DONE  | word complete, valid_out held until ready_in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_TC = 4'(SETTLE);

    state_t     state;
    logic [3:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            S         <= 2'd0;
            data_out  <= 4'd0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        S        <= 2'd0;
                        hold_cnt <= 4'd0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hold_cnt == HOLD_TC) begin
                        // last edge of this select's hold: capture, then advance
                        data_out[S] <= mux_o;
                        hold_cnt    <= 4'd0;
                        if (S == 2'd3) begin
                            state     <= DONE;
                            valid_out <= 1'b1;
                        end else begin
                            S <= S + 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        state     <= IDLE;
                        valid_out <= 1'b0;
                        busy      <= 1'b0;
                        S         <= 2'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    S         <= 2'd0;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                    hold_cnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=0 and SETTLE=2) each driving
// a modelled 4:1 mux; table vectors, hand sequences and random scans.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] ready_v;
    logic [3:0] d_v [2];

    logic [1:0] s0, s1;
    logic [3:0] dat0, dat1;
    logic       v0, v1, b0, b1;
    logic       mux0, mux1;

    int total = 0;
    int bad   = 0;
    logic [3:0] prev_word [2];

    always #5 clk = ~clk;

    assign mux0 = d_v[0][s0];
    assign mux1 = d_v[1][s1];

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .S(s0), .mux_o(mux0),
        .data_out(dat0), .valid_out(v0), .ready_in(ready_v[0]), .busy(b0)
    );

    mux_scan_ctrl #(.SETTLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .S(s1), .mux_o(mux1),
        .data_out(dat1), .valid_out(v1), .ready_in(ready_v[1]), .busy(b1)
    );

    typedef struct {
        logic [3:0] d;
        int         delay;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic int settle_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int get_s(input int i);
        return (i == 0) ? int'(s0) : int'(s1);
    endfunction
    function automatic int get_dat(input int i);
        return (i == 0) ? int'(dat0) : int'(dat1);
    endfunction
    function automatic int get_v(input int i);
        return (i == 0) ? int'(v0) : int'(v1);
    endfunction
    function automatic int get_b(input int i);
        return (i == 0) ? int'(b0) : int'(b1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic begin_scan(input int i, input logic [3:0] d);
        @(negedge clk);
        d_v[i]     = d;
        start_v[i] = 1'b1;
        @(posedge clk);
    endtask

    // Called just after the edge that accepted start. The reference:
    // after k cycles S = k/(SETTLE+1); bits below S are new, others keep the old word.
    task automatic run_scan(input int i, input logic [3:0] exp, input int delay,
                            input bit hold_start, input bit ready_early);
        int set = settle_of(i);
        int n   = 4 * (set + 1);
        logic [3:0] part;
        #1;
        start_v[i] = hold_start;
        ready_v[i] = ready_early;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            part = prev_word[i];
            for (int j = 0; j < k / (set + 1); j++) part[j] = exp[j];
            chk("scan_S", get_s(i), k / (set + 1));
            chk("scan_busy", get_b(i), 1);
            chk("scan_valid", get_v(i), 0);
            chk("scan_partial", get_dat(i), int'(part));
        end
        @(negedge clk);
        chk("done_valid", get_v(i), 1);
        chk("done_data", get_dat(i), int'(exp));
        chk("done_S", get_s(i), 3);
        chk("done_busy", get_b(i), 1);
        if (!ready_early) begin
            for (int r = 0; r < delay; r++) begin
                d_v[i] = 4'($urandom);
                @(negedge clk);
                chk("hold_valid", get_v(i), 1);
                chk("hold_data", get_dat(i), int'(exp));
                chk("hold_S", get_s(i), 3);
            end
            ready_v[i] = 1'b1;
        end
        @(negedge clk);
        chk("idle_valid", get_v(i), 0);
        chk("idle_busy", get_b(i), 0);
        chk("idle_S", get_s(i), 0);
        chk("idle_data", get_dat(i), int'(exp));
        ready_v[i] = 1'b0;
        start_v[i] = 1'b0;
        prev_word[i] = exp;
    endtask

    initial begin
        rst_n     = 1'b0;
        start_v   = 2'b00;
        ready_v   = 2'b00;
        d_v[0]    = 4'd0;
        d_v[1]    = 4'd0;
        prev_word[0] = 4'd0;
        prev_word[1] = 4'd0;

        vecs.push_back('{d: 4'b1010, delay: 0, exp: 4'b1010});
        vecs.push_back('{d: 4'b1111, delay: 5, exp: 4'b1111});
        vecs.push_back('{d: 4'b0001, delay: 0, exp: 4'b0001});
        for (int v = 0; v < 16; v++)
            vecs.push_back('{d: 4'(v), delay: v % 3, exp: 4'(v)});

        #1;
        chk("rst_S0", int'(s0), 0);
        chk("rst_dat0", int'(dat0), 0);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_busy0", int'(b0), 0);
        chk("rst_busy1", int'(b1), 0);
        #20;
        rst_n = 1'b1;

        // table vectors on the SETTLE=0 instance
        for (int t = 0; t < vecs.size(); t++) begin
            begin_scan(0, vecs[t].d);
            run_scan(0, vecs[t].exp, vecs[t].delay, 1'b0, 1'b0);
        end

        // SETTLE=2: each select held 3 cycles, valid after 12
        begin_scan(1, 4'b0110);
        run_scan(1, 4'b0110, 1, 1'b0, 1'b0);

        // start held high through scan and handshake; handshake edge must not restart
        begin_scan(0, 4'b1001);
        run_scan(0, 4'b1001, 2, 1'b1, 1'b0);
        @(negedge clk);
        chk("no_restart_busy", int'(b0), 0);

        // reset while S=2 mid-scan, then restart on the first edge after release
        begin_scan(0, 4'b1111);
        #1;
        start_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("pre_rst_S", int'(s0), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_S", int'(s0), 0);
        chk("async_rst_dat", int'(dat0), 0);
        chk("async_rst_valid", int'(v0), 0);
        chk("async_rst_busy", int'(b0), 0);
        prev_word[0] = 4'd0;
        prev_word[1] = 4'd0;
        d_v[0]     = 4'b0101;
        start_v[0] = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk);
        run_scan(0, 4'b0101, 0, 1'b0, 1'b0);

        // random scans on either instance
        for (int r = 0; r < 30; r++) begin
            int   i  = int'($urandom_range(0, 1));
            logic [3:0] d = 4'($urandom);
            int   dl = int'($urandom_range(0, 3));
            bit   hs = 1'($urandom_range(0, 1));
            bit   re = (dl == 0) && ($urandom_range(0, 1) == 1);
            begin_scan(i, d);
            run_scan(i, d, dl, hs, re);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
